// File: rtl/noise_flash_scheduler.sv
// Queues per-channel noise events in saturating counters and replays them, round-robin,
// as fixed-length flashes on a shared diode engine with a mandatory dark gap after each.
module noise_flash_scheduler #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 4,
  parameter int FLASH_LEN = 8,
  parameter int GAP_LEN   = 2,
  localparam int AW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noise_pulse,
  input  logic            enable,
  input  logic            clear_ovf,
  output logic [N_CH-1:0] diode_out,
  output logic [AW-1:0]   active_ch,
  output logic            busy,
  output logic            pending_any,
  output logic [N_CH-1:0] overflow,
  output logic            flash_done
);

  localparam int TMAX = (FLASH_LEN > GAP_LEN) ? FLASH_LEN : GAP_LEN;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_FLASH, S_GAP} state_t;

  state_t           r_state, w_state_nx;
  logic [TW-1:0]    r_timer, w_timer_nx;
  logic [N_CH-1:0]  r_diode, w_diode_nx;
  logic [AW-1:0]    r_active_ch, w_active_nx;
  logic [N_CH-1:0]  r_overflow;
  logic [CNT_W-1:0] r_cnt [N_CH];

  logic [N_CH-1:0]  w_nz;
  logic [N_CH-1:0]  w_grant_oh;
  logic [N_CH-1:0]  w_ovf_set;
  logic [N_CH-1:0]  w_pick_oh;
  logic [AW-1:0]    w_pick;
  logic [AW-1:0]    w_idx;
  logic             w_found;
  logic             w_grant;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_nz[i] = (r_cnt[i] != '0);
    end
  end

  // Round-robin search starts just after the last-granted channel.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_active_ch;
    w_idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = AW'((int'(r_active_ch) + k) % N_CH);
      if (!w_found && w_nz[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_pick_oh = {{(N_CH-1){1'b0}}, 1'b1} << w_pick;

  always_comb begin
    w_state_nx  = r_state;
    w_timer_nx  = r_timer;
    w_diode_nx  = r_diode;
    w_active_nx = r_active_ch;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_found) begin
          w_grant     = 1'b1;
          w_state_nx  = S_FLASH;
          w_timer_nx  = TW'(FLASH_LEN - 1);
          w_diode_nx  = w_pick_oh;
          w_active_nx = w_pick;
        end
      end
      S_FLASH: begin
        if (r_timer == '0) begin
          w_state_nx = S_GAP;
          w_timer_nx = TW'(GAP_LEN - 1);
          w_diode_nx = '0;
        end else begin
          w_timer_nx = r_timer - 1'b1;
        end
      end
      S_GAP: begin
        if (r_timer == '0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_timer_nx = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_diode_nx = '0;
      end
    endcase
  end

  assign w_grant_oh = w_grant ? w_pick_oh : '0;

  // A pulse coinciding with a grant cancels it out, so no overflow is possible then.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_ovf_set[i] = noise_pulse[i] && !w_grant_oh[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_diode     <= '0;
      r_active_ch <= AW'(N_CH - 1);
    end else begin
      r_state     <= w_state_nx;
      r_timer     <= w_timer_nx;
      r_diode     <= w_diode_nx;
      r_active_ch <= w_active_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (noise_pulse[i] && !w_grant_oh[i]) begin
          if (r_cnt[i] != CNT_MAX) begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else if (w_grant_oh[i] && !noise_pulse[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Clearing wins over a same-cycle overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= '0;
    end else if (clear_ovf) begin
      r_overflow <= '0;
    end else begin
      r_overflow <= r_overflow | w_ovf_set;
    end
  end

  assign diode_out   = r_diode;
  assign active_ch   = r_active_ch;
  assign busy        = (r_state != S_IDLE);
  assign pending_any = |w_nz;
  assign overflow    = r_overflow;
  assign flash_done  = (r_state == S_FLASH) && (r_timer == '0);

endmodule

// File: doc/noise_flash_scheduler.md
Name: noise_flash_scheduler

Overview:
- Shares one diode flash engine among N_CH noise channels.
- Each channel delivers single-cycle, clk-synchronous event pulses from its own noise synchroniser stage.
- Per-channel saturating counters queue the events. A round-robin scheduler then replays each queued event as one fixed-length flash on that channel's diode, followed by a mandatory dark gap.

Parameters:
- N_CH, 4, number of noise channels / diodes (2..16).
- CNT_W, 4, width of each pending-event counter; saturates at 2^CNT_W-1.
- FLASH_LEN, 8, cycles a diode is lit per event (>=1).
- GAP_LEN, 2, dark cycles after every flash before the next grant (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- noise_pulse  in  N_CH  single-cycle event pulses, one bit per channel, synchronous to clk
- enable  in  1  1 = new grants allowed; 0 = no new grant, a flash in progress completes
- clear_ovf  in  1  synchronous clear of all overflow flags
- diode_out  out  N_CH  one-hot (or zero) diode drive, registered
- active_ch  out  clog2(N_CH) (min 1)  index of the lit/last-granted channel
- busy  out  1  high in FLASH or GAP
- pending_any  out  1  OR of (counter != 0) over all channels
- overflow  out  N_CH  sticky: event lost on that channel at saturation
- flash_done  out  1  one-cycle pulse on the last FLASH cycle

Behaviour:
- Reset (async, active-high):
  - counters = 0, state = IDLE, diode_out = 0, active_ch = N_CH-1 (so channel 0 has first priority).
  - busy = 0, overflow = 0, flash_done = 0, timer = 0.
- Counters (per channel i, each edge):
  - inc = noise_pulse[i]; dec = grant this edge to channel i.
  - inc & !dec: +1, unless at max. At max the value holds and overflow[i] <= 1.
  - dec & !inc: -1. A grant only happens when the counter is nonzero.
  - inc & dec: value unchanged, no overflow.
  - clear_ovf has priority over setting: when clear_ovf and a new overflow occur in the same cycle, overflow[i] ends at 0.
- FSM states:
  - IDLE:
    - Exit condition: enable=1 and any registered counter nonzero. The current-cycle pulse is not visible to this decision.
    - Channel choice: round-robin, searching from active_ch+1 upward with wrap-around; the first nonzero channel wins.
    - On that edge: state<=FLASH, diode_out<=onehot(ch), active_ch<=ch, decrement that channel's counter, timer<=FLASH_LEN-1.
  - FLASH:
    - diode_out holds its value; timer decrements each cycle.
    - When timer==0: flash_done=1 for that cycle; next edge state<=GAP, diode_out<=0, timer<=GAP_LEN-1.
  - GAP:
    - diode_out=0; timer decrements.
    - When timer==0: next edge state<=IDLE.
- busy = (state != IDLE), registered consistently with diode_out.
- Latency and timing:
  - A pulse at edge k sets the counter after edge k. If the FSM is IDLE, diode_out rises after edge k+1 (2-cycle latency).
  - Each flash is exactly FLASH_LEN cycles, followed by exactly GAP_LEN dark cycles and one IDLE cycle.
  - Minimum event period per grant = FLASH_LEN+GAP_LEN+1 cycles.
- enable:
  - Dropping enable mid-FLASH or mid-GAP does not truncate the flash or gap.
  - While enable=0, counters still accumulate events.
- Reset mid-flash: diode_out drops asynchronously; all queued events are discarded.
- pending_any is combinational from the counters.

Test Plan:
- Single event: reset, pulse ch2 once at cycle 10 -> diode_out=4'b0100 for cycles 12..19 (8 cycles); flash_done at cycle 19; dark at 20..21; busy low at 22; pending_any low from cycle 12.
- Round-robin: pulse ch0, ch1 and ch3 in the same cycle -> flashes ordered ch0, ch1, ch3, each 8 cycles with 2-cycle gaps. Next, pulse ch0 and ch3 together -> ch3 is served before ch0 only if active_ch points between them (active_ch=1 gives ch3 then ch0).
- Saturation: 17 pulses on ch1 with enable=0 -> counter=15, overflow[1]=1. Then enable=1 -> exactly 15 flashes on ch1. A clear_ovf pulse -> overflow=0.
- Simultaneous inc/dec: pulse ch0 on the exact edge ch0 is granted while its count is 1 -> count stays 1, a second flash follows after the gap.
- Enable drop: deassert enable at cycle 3 of a flash -> the flash completes its 8 cycles plus the gap; no new grant while pending_any=1 until enable returns.
- Async reset mid-flash: assert reset between edges during FLASH -> diode_out=0 and busy=0 immediately, counters=0; no flash after reset release.
